// File: rtl/delay_trigger_bank.sv
// delay_trigger_bank: bank of independent delayed-enable generators.
// Each channel detects a rising edge on its trigger line and loads a delay.
// It counts that delay down, then asserts fire as a one-cycle pulse
// (PULSE_MODE=1) or as a held level (PULSE_MODE=0).
// Ports:
//   clock_50      system clock, rising edge
//   reset_button  synchronous active-high reset
//   trig          per-channel trigger level; the event is its rising edge
//   delay         per-channel delay, channel i at [i*CNT_W +: CNT_W]
//   cancel        per-channel abort, level-sampled, beats a trigger event
//   fire          registered delayed enable
//   busy          registered, high while the channel is counting
module delay_trigger_bank #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PULSE_MODE = 1,
  parameter int unsigned RETRIGGER  = 1
) (
  input  logic                      clock_50,
  input  logic                      reset_button,
  input  logic [CHANNELS-1:0]       trig,
  input  logic [CHANNELS*CNT_W-1:0] delay,
  input  logic [CHANNELS-1:0]       cancel,
  output logic [CHANNELS-1:0]       fire,
  output logic [CHANNELS-1:0]       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               RETRIG_EN = (RETRIGGER != 0);
  localparam bit               PULSE_EN  = (PULSE_MODE != 0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             trig_q;
    logic [CNT_W-1:0] cnt_q;
    state_e           state_q;
    logic             fire_q;
    logic             busy_q;
    logic             event_c;
    logic [CNT_W-1:0] dly_c;

    assign event_c = trig[i] & ~trig_q;
    assign dly_c   = delay[i*CNT_W +: CNT_W];

    // Per-channel state machine with registered fire/busy.
    always_ff @(posedge clock_50) begin
      if (reset_button) begin
        trig_q  <= 1'b0;
        cnt_q   <= '0;
        state_q <= ST_IDLE;
        fire_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        trig_q <= trig[i];
        if (cancel[i]) begin
          // Any coincident trigger event is dropped; trig_q still tracks trig.
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          fire_q  <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (event_c) begin
                cnt_q   <= dly_c;
                state_q <= ST_COUNT;
                busy_q  <= 1'b1;
              end
            end
            ST_COUNT: begin
              // A reload beats the terminal count; stopping at 1 makes
              // delays 0 and 1 equivalent and prevents wrap.
              if (event_c && RETRIG_EN) begin
                cnt_q <= dly_c;
              end else if (cnt_q <= CNT_ONE) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                fire_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q - CNT_ONE;
              end
            end
            ST_DONE: begin
              // A new event restarts in both modes; pulse mode otherwise
              // leaves DONE after one cycle, level mode holds.
              if (event_c) begin
                fire_q  <= 1'b0;
                cnt_q   <= dly_c;
                state_q <= ST_COUNT;
                busy_q  <= 1'b1;
              end else if (PULSE_EN) begin
                fire_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              fire_q  <= 1'b0;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign fire[i] = fire_q;
    assign busy[i] = busy_q;
  end

endmodule

// File: tb/tb_delay_trigger_bank.sv
// Bench for delay_trigger_bank. It drives three configurations from shared
// inputs: A (pulse, retrigger), B (pulse, no retrigger) and C (level,
// retrigger). A deadline-based model is compared on every cycle, and
// directed literal expectations pin the key timing points.
module tb_delay_trigger_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] trig;
  logic [15:0] delay;
  logic [1:0] cancel;
  logic [1:0] fire_w [3];
  logic [1:0] busy_w [3];

  int vec_cnt  = 0;
  int miss_cnt = 0;
  bit chk_en   = 1'b0;

  always #10 clk = ~clk;

  delay_trigger_bank #(.CHANNELS(2), .CNT_W(8), .PULSE_MODE(1), .RETRIGGER(1)) u_a (
    .clock_50(clk), .reset_button(rst), .trig(trig), .delay(delay),
    .cancel(cancel), .fire(fire_w[0]), .busy(busy_w[0]));
  delay_trigger_bank #(.CHANNELS(2), .CNT_W(8), .PULSE_MODE(1), .RETRIGGER(0)) u_b (
    .clock_50(clk), .reset_button(rst), .trig(trig), .delay(delay),
    .cancel(cancel), .fire(fire_w[1]), .busy(busy_w[1]));
  delay_trigger_bank #(.CHANNELS(2), .CNT_W(8), .PULSE_MODE(0), .RETRIGGER(1)) u_c (
    .clock_50(clk), .reset_button(rst), .trig(trig), .delay(delay),
    .cancel(cancel), .fire(fire_w[2]), .busy(busy_w[2]));

  // Model: a pending channel fires at the absolute edge number "at".
  typedef struct packed {
    bit p;
    bit f;
    int a;
  } ms_t;

  ms_t      m_st [3][2];
  bit [1:0] m_prev = 2'b00;
  int       n      = 0;

  function automatic int eff_delay(input logic [7:0] v);
    return (v == 8'd0) ? 1 : 32'(v);
  endfunction

  function automatic ms_t mstep(input ms_t s, input bit r, input bit cx, input bit ev,
                                input int dd, input int nn, input bit pulse,
                                input bit retrig);
    ms_t o;
    o = s;
    if (r || cx) begin
      o.p = 1'b0;
      o.f = 1'b0;
    end else if (s.p) begin
      if (ev && retrig) o.a = nn + dd;
      else if (nn == s.a) begin
        o.p = 1'b0;
        o.f = 1'b1;
      end
    end else if (ev) begin
      o.f = 1'b0;
      o.p = 1'b1;
      o.a = nn + dd;
    end else if (s.f && pulse) begin
      o.f = 1'b0;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 3; d++) begin
        m_st[d][c] <= mstep(m_st[d][c], rst, cancel[c], trig[c] & ~m_prev[c],
                            eff_delay(delay[c*8 +: 8]), n + 1, d != 2, d != 1);
      end
      m_prev[c] <= rst ? 1'b0 : trig[c];
    end
    n <= n + 1;
  end

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare all instances against the model.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("model_fire[%0d]", d), fire_w[d], {m_st[d][1].f, m_st[d][0].f});
        chk($sformatf("model_busy[%0d]", d), busy_w[d], {m_st[d][1].p, m_st[d][0].p});
      end
    end
  endtask

  task automatic clear_all();
    cancel = 2'b11;
    tick();
    cancel = 2'b00;
    tick();
  endtask

  initial begin
    int nf;
    rst = 1'b1; trig = 2'b00; cancel = 2'b00; delay = 16'd0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_fire_a", fire_w[0], 2'b00);
    chk("rst_busy_c", busy_w[2], 2'b00);
    rst = 1'b0;

    // Single trigger, D0=30, channel 1 silent.
    delay = {8'd0, 8'd30};
    repeat (8) tick();
    trig = 2'b01;
    repeat (30) tick();
    chk("s1_busy_last", busy_w[0], 2'b01);
    chk("s1_fire_early", fire_w[0], 2'b00);
    tick();
    chk("s1_fire", fire_w[0], 2'b01);
    chk("s1_busy_off", busy_w[0], 2'b00);
    tick();
    chk("s1_fire_pulse_end", fire_w[0], 2'b00);
    chk("s1_fire_level", fire_w[2], 2'b01);
    trig = 2'b00;
    clear_all();

    // Two channels in parallel, D0=30, D1=60.
    delay = {8'd60, 8'd30};
    trig = 2'b11;
    repeat (30) tick();
    chk("s2_pre0", fire_w[0], 2'b00);
    tick();
    chk("s2_fire0", fire_w[0], 2'b01);
    trig = 2'b00;
    repeat (29) tick();
    chk("s2_pre1", fire_w[0], 2'b00);
    tick();
    chk("s2_fire1", fire_w[0], 2'b10);
    clear_all();

    // Retrigger at E+15 with D=20.
    delay = {8'd0, 8'd20};
    trig = 2'b01;
    repeat (5) tick();
    trig = 2'b00;
    repeat (10) tick();
    trig = 2'b01;
    repeat (6) tick();
    chk("s3_noretrig_fire", fire_w[1], 2'b01);
    chk("s3_retrig_quiet", fire_w[0], 2'b00);
    chk("s3_retrig_busy", busy_w[0], 2'b01);
    repeat (15) tick();
    chk("s3_retrig_fire", fire_w[0], 2'b01);
    trig = 2'b00;
    clear_all();

    // Level mode, D=5, new trigger at E+12.
    delay = {8'd0, 8'd5};
    trig = 2'b01;
    repeat (3) tick();
    trig = 2'b00;
    repeat (3) tick();
    chk("s4_level_on", fire_w[2], 2'b01);
    chk("s4_pulse_on", fire_w[0], 2'b01);
    tick();
    chk("s4_level_held", fire_w[2], 2'b01);
    chk("s4_pulse_off", fire_w[0], 2'b00);
    repeat (5) tick();
    trig = 2'b01;
    chk("s4_level_still", fire_w[2], 2'b01);
    tick();
    chk("s4_level_cleared", fire_w[2], 2'b00);
    chk("s4_level_busy", busy_w[2], 2'b01);
    repeat (5) tick();
    chk("s4_level_refire", fire_w[2], 2'b01);
    trig = 2'b00;
    clear_all();

    // Cancel together with a new trigger rise at E+4; trig then held high.
    delay = {8'd0, 8'd10};
    trig = 2'b01;
    repeat (2) tick();
    trig = 2'b00;
    repeat (2) tick();
    cancel = 2'b01;
    trig = 2'b01;
    tick();
    cancel = 2'b00;
    chk("s5_cancel_fire", fire_w[0], 2'b00);
    chk("s5_cancel_busy", busy_w[0], 2'b00);
    nf = 0;
    repeat (40) begin
      tick();
      if (fire_w[0][0] || fire_w[2][0]) nf++;
    end
    chk("s5_cancel_nofire", {1'b0, nf != 0}, 2'b00);
    trig = 2'b00;
    tick();

    // Reset pulsed mid-count.
    trig = 2'b01;
    repeat (2) tick();
    trig = 2'b00;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_reset_busy", busy_w[0], 2'b00);
    nf = 0;
    repeat (20) begin
      tick();
      if (fire_w[0][0]) nf++;
    end
    chk("s5_reset_nofire", {1'b0, nf != 0}, 2'b00);

    // Boundary delays: D=0 and D=1 both fire after E+1.
    delay = {8'd1, 8'd0};
    trig = 2'b11;
    tick();
    chk("s6_d01_busy", busy_w[0], 2'b11);
    chk("s6_d01_pre", fire_w[0], 2'b00);
    tick();
    chk("s6_d01_fire", fire_w[0], 2'b11);
    trig = 2'b00;
    tick();
    clear_all();

    // D=255; a later delay change must not disturb the running count.
    delay = {8'd0, 8'd255};
    trig = 2'b01;
    repeat (10) tick();
    delay = {8'd0, 8'd3};
    trig = 2'b00;
    repeat (245) tick();
    chk("s6_d255_pre", fire_w[0], 2'b00);
    chk("s6_d255_busy", busy_w[0], 2'b01);
    tick();
    chk("s6_d255_fire", fire_w[0], 2'b01);
    clear_all();

    // Trigger held high across reset release, D=7.
    rst = 1'b1;
    trig = 2'b01;
    delay = {8'd0, 8'd7};
    repeat (3) tick();
    rst = 1'b0;
    repeat (7) tick();
    chk("s7_pre", fire_w[0], 2'b00);
    tick();
    chk("s7_fire", fire_w[0], 2'b01);
    trig = 2'b00;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/delay_trigger_bank.md
# delay_trigger_bank

Parametrised bank of independent delayed-enable generators clocked from `clock_50`. Each channel watches its own trigger line (reset, game-over, level-start and similar game events), waits a run-time programmable number of clock cycles, then asserts its output as a one-cycle pulse or a held level. Game and display logic use these outputs as synthesizable enables. The block replaces per-event hard-coded delay generators with one bank. Each channel adds cancel, retrigger policy and a busy flag.

## Interface
- `CHANNELS`, default 2: number of independent channels.
- `CNT_W`, default 8: counter and delay width; maximum delay is 2^CNT_W-1 cycles.
- `PULSE_MODE`, default 1: 1 = `fire` is a one-cycle pulse; 0 = `fire` holds high until the next trigger event, cancel or reset.
- `RETRIGGER`, default 1: 1 = a trigger event while counting reloads the delay; 0 = the event is ignored while counting.

- `clock_50`  in  1  system clock. All logic is on its rising edge.
- `reset_button`  in  1  reset. Synchronous, active-high.
- `trig`  in  CHANNELS  per-channel trigger level. The event is its rising edge.
- `delay`  in  CHANNELS*CNT_W  per-channel delay in cycles. Channel i uses bits [i*CNT_W +: CNT_W].
- `cancel`  in  CHANNELS  per-channel abort, active-high, level-sampled.
- `fire`  out  CHANNELS  registered delayed enable.
- `busy`  out  CHANNELS  registered; high while the channel is counting.

## Operation
- Each channel has its own registers: `trig_q`, counter `cnt[CNT_W]`, and state IDLE / COUNT / DONE. Channels never interact.
- Event: `trig[i]` & ~`trig_q[i]`, evaluated at each edge. `trig_q` is loaded from `trig` every non-reset edge.
- IDLE on event: `cnt` <= `delay[i]`, go to COUNT, `busy` <= 1. The delay value is captured only at this edge. Later changes to `delay` do not affect a running count.
- COUNT at each edge without event or cancel:
  - if `cnt` <= 1: go to DONE, `busy` <= 0, `fire` <= 1;
  - else `cnt` <= `cnt`-1.
- DONE, pulse mode: the next edge clears `fire` and returns to IDLE. A trigger event at that edge is accepted as an IDLE event.
- DONE, level mode: stay in DONE with `fire`=1. A trigger event clears `fire` and enters COUNT with the new delay. Cancel clears `fire` and returns to IDLE.
- Event in COUNT:
  - `RETRIGGER`=1: reload `cnt` with the current `delay[i]` and stay in COUNT. This applies even at the terminal count edge; the reload wins and `fire` does not assert.
  - `RETRIGGER`=0: the event is ignored and the count proceeds. The fire edge still occurs.
- Cancel, any state: IDLE, `fire` <= 0, `busy` <= 0, `cnt` <= 0. Cancel has priority over a simultaneous trigger event; that event is discarded, and a trigger held high afterwards does not re-fire without a new rising edge.
- A delay of 0 behaves exactly as a delay of 1.
- Unsigned arithmetic only. The counter never wraps, because decrement stops at 1.

## Timing
- Reset (`reset_button`=1 at an edge): all channels go to IDLE. `fire`=0, `busy`=0, `cnt`=0, `trig_q`=0. Reset overrides every other input, including mid-count and DONE.
- Because `trig_q` resets to 0, a trigger already high at the first edge after reset release is an event. This gives "delay N cycles after reset" with `trig` tied to the reset source.
- Latency: event at edge E with delay D≥1 puts `busy` high from E to E+D. `fire` is high after edge E+D and is sampled by downstream logic at edge E+D+1.
- Pulse mode: `fire` is high for exactly one cycle.
- Minimum event-to-event spacing for back-to-back pulse-mode firings is D+1 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then single trigger: CHANNELS=2, D0=30. Rise `trig[0]` at edge 10. Required: `busy[0]` high for edges 10–39, `fire[0]` high for exactly the cycle after edge 40, channel 1 silent.
- Two channels in parallel: D0=30, D1=60, both triggered at the same edge E. Required: `fire[0]` after E+30 and `fire[1]` after E+60, independent of each other.
- Retrigger: D=20, trigger at E, second rising edge at E+15.
  - `RETRIGGER`=1: fire after E+35 only.
  - `RETRIGGER`=0: fire after E+20 only.
- Level mode: `PULSE_MODE`=0, D=5, trigger at E. Required: `fire` high from E+5 and held. New trigger at E+12: `fire` low after E+12, high again after E+17.
- Cancel priority: D=10, trigger at E, cancel together with a new trigger rise at E+4. Required: `fire` and `busy` low after E+4, no fire through E+40. `reset_button` pulsed mid-count gives the same result.
- Boundary delays: D=0 and D=1 both fire after E+1; D=255 fires after E+255. A trigger held high across reset release fires D cycles after the first post-reset edge.
